// File: rtl/mux_rr_pkg.sv
// Shared helpers for the round-robin registered mux: index-width function and reset values.
package mux_rr_pkg;

    localparam logic RESET_SEL = 1'b0;

    // Channel-index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// One-hot arbiter for mux_rr_reg. The rotating pointer advances only on an accepted grant.
// Build option MUX_RR_FIXED_PRI_EN: fixed priority (lowest index wins), no pointer.
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int SEL_W = idx_w(N);

`ifdef MUX_RR_FIXED_PRI_EN
    logic found_s;
    logic hit_s;

    // Lowest requesting index wins.
    always_comb begin
        grant   = {N{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit_s    = req[i] & ~found_s;
            grant[i] = hit_s;
            found_s  = found_s | hit_s;
        end
    end
`else
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] nxt_ptr_s;
    logic             found_s;
    logic             hit_s;
    int               idx_s;

    // Scan from ptr upward (mod N), grant the first requester and work out the pointer after it.
    always_comb begin
        grant     = {N{1'b0}};
        found_s   = 1'b0;
        hit_s     = 1'b0;
        idx_s     = 0;
        nxt_ptr_s = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx_s        = (int'(ptr_q) + k) % N;
            hit_s        = req[idx_s] & ~found_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            nxt_ptr_s    = hit_s ? ((idx_s == N - 1) ? {SEL_W{1'b0}} : SEL_W'(idx_s + 1))
                                 : nxt_ptr_s;
            found_s      = found_s | hit_s;
        end
        ptr_d = advance ? nxt_ptr_s : ptr_q;
    end

    // Pointer register; idle cycles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {SEL_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel, W-bit valid/ready mux with internal arbitration and a one-beat output register.
// Build option MUX_RR_FIXED_PRI_EN selects fixed-priority arbitration inside rr_arbiter.
module mux_rr_reg
    import mux_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int SEL_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    logic [N-1:0]     grant_s;
    logic             load_s;
    logic             xfer_s;
    logic [W-1:0]     data_s;
    logic [SEL_W-1:0] sel_s;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (xfer_s),
        .grant   (grant_s)
    );

    // The register can take a new beat when it is empty or being popped this cycle.
    always_comb begin
        load_s   = ~out_valid_q | out_ready;
        in_ready = rst ? {N{1'b0}} : (grant_s & {N{load_s}});
        xfer_s   = |(in_valid & in_ready);
    end

    // AND-OR select of the granted channel's data and its index.
    always_comb begin
        data_s = {W{1'b0}};
        sel_s  = {SEL_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            data_s = data_s | (in_data[i*W +: W] & {W{grant_s[i]}});
            sel_s  = sel_s | (grant_s[i] ? SEL_W'(i) : {SEL_W{1'b0}});
        end
    end

    // Next state: a transfer replaces the beat, a pop without transfer empties it, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = data_s;
            out_sel_d   = sel_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_sel_q   <= {SEL_W{RESET_SEL}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed self-checking bench for mux_rr_reg with N=4, W=4.
module tb_mux_rr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    mux_rr_reg #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 16'h4321;
        out_ready = 1'b0;
        step();
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp %b", in_ready, 4'b0000); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp %b", out_valid, 1'b0); end
        checks++;
        if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, 4'h0); end
        checks++;
        if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d exp %0d", out_sel, 0); end
        in_valid = 4'b0000;
        rst      = 1'b0;
    endtask

    task automatic test_single();
        in_valid  = 4'b0100;
        in_data   = 16'h0A00;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b exp %b", in_ready, 4'b0100); end
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp %b", out_valid, 1'b1); end
        checks++;
        if (out_data !== 4'hA) begin errors++; $display("FAIL single_data got %h exp %h", out_data, 4'hA); end
        checks++;
        if (out_sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d exp %0d", out_sel, 2); end
        in_valid = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b exp %b", out_valid, 1'b0); end
        checks++;
        if (out_data !== 4'hA) begin errors++; $display("FAIL single_pop_data got %h exp %h", out_data, 4'hA); end
    endtask

    // ptr is 3 after channel 2 was served.
    task automatic test_wrap();
        in_valid = 4'b0001;
        in_data  = 16'h0007;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_in_ready got %b exp %b", in_ready, 4'b0001); end
        step();
        checks++;
        if (out_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel got %0d exp %0d", out_sel, 0); end
        checks++;
        if (out_data !== 4'h7) begin errors++; $display("FAIL wrap_data got %h exp %h", out_data, 4'h7); end
        in_valid = 4'b0011;
        in_data  = 16'h0097;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1_in_ready got %b exp %b", in_ready, 4'b0010); end
        step();
        checks++;
        if (out_sel !== 2'd1) begin errors++; $display("FAIL wrap_ptr1_sel got %0d exp %0d", out_sel, 1); end
        checks++;
        if (out_data !== 4'h9) begin errors++; $display("FAIL wrap_ptr1_data got %h exp %h", out_data, 4'h9); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp %b", out_valid, 1'b0); end
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL midreset_in_ready got %b exp %b", in_ready, 4'b0000); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_data [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        logic [3:0] exp_rdy;
        in_valid  = 4'b1111;
        in_data   = 16'h4321;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << exp_sel[k];
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL rot_in_ready[%0d] got %b exp %b", k, in_ready, exp_rdy); end
            step();
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d] got %b exp %b", k, out_valid, 1'b1); end
            checks++;
            if (out_sel !== exp_sel[k]) begin errors++; $display("FAIL rot_sel[%0d] got %0d exp %0d", k, out_sel, exp_sel[k]); end
            checks++;
            if (out_data !== exp_data[k]) begin errors++; $display("FAIL rot_data[%0d] got %h exp %h", k, out_data, exp_data[k]); end
        end
    endtask

    // ptr is 1 after the rotation; channel 1 carries 4'h5.
    task automatic test_backpressure();
        in_valid  = 4'b1111;
        in_data   = 16'h4351;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_first_sel got %0d exp %0d", out_sel, 1); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp %b", k, in_ready, 4'b0000); end
            step();
            checks++;
            if (out_data !== 4'h5) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", k, out_data, 4'h5); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp %b", k, out_valid, 1'b1); end
            checks++;
            if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d] got %0d exp %0d", k, out_sel, 1); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_in_ready got %b exp %b", in_ready, 4'b0100); end
        step();
        checks++;
        if (out_sel !== 2'd2) begin errors++; $display("FAIL bp_release_sel got %0d exp %0d", out_sel, 2); end
        checks++;
        if (out_data !== 4'h3) begin errors++; $display("FAIL bp_release_data got %h exp %h", out_data, 4'h3); end
    endtask

    task automatic test_mode();
        in_valid  = 4'b1111;
        in_data   = 16'h4321;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_sel !== 2'd0) begin errors++; $display("FAIL mode_sel[%0d] got %0d exp %0d", k, out_sel, 0); end
            checks++;
            if (out_data !== 4'h1) begin errors++; $display("FAIL mode_data[%0d] got %h exp %h", k, out_data, 4'h1); end
        end
    endtask

    initial begin
        test_reset();
`ifdef MUX_RR_FIXED_PRI_EN
        test_mode();
`else
        test_single();
        test_wrap();
        test_reset_mid();
        test_rotation();
        test_backpressure();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
